or_gate_tester: RTL and testbench

- Synthesizable exhaustive stimulus driver and response checker for an N-input OR gate DUT, such as the 3-input gate-level OR with two chained 2-input stages.
- Replaces the hand-written per-vector testbench sequence: walks every input combination, waits a settle interval, compares the DUT output against reduction-OR, and counts mismatches.
- Sits beside the DUT in the lab top level: the tester drives the DUT inputs and receives its output.

---
 rtl/or_tester_pkg.sv | 14 +
 rtl/or_gate_tester_settle_timer.sv | 31 +++
 rtl/or_gate_tester.sv | 124 ++++++++++++
 tb/tb_or_gate_tester.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/or_tester_pkg.sv
// Shared types and default constants for the exhaustive OR-gate tester.
package or_tester_pkg;

    localparam int DEF_N_IN          = 3;
    localparam int DEF_SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/or_gate_tester_settle_timer.sv
// Counts the cycles a vector has been held; expired flags the last hold cycle.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Wide enough to hold SETTLE_CYCLES itself, which is reached on the expiry edge.
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/or_gate_tester.sv
// Exhaustive stimulus driver and checker for an N_IN-input OR gate.
// Optional first-failure capture ports are built when OR_TESTER_FIRST_FAIL_EN is defined.
module or_gate_tester
    import or_tester_pkg::*;
#(
    parameter int N_IN          = DEF_N_IN,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count
`ifdef OR_TESTER_FIRST_FAIL_EN
    ,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
`endif
);

    state_t          state;
    state_t          next_state;
    logic [N_IN-1:0] vec;
    logic [N_IN:0]   err_next;
    logic            mismatch;
    logic            last_vec;
    logic            timer_clear;
    logic            timer_en;
    logic            timer_expired;

    assign mismatch = (dut_out != (|vec));
    assign last_vec = &vec;
    assign err_next = err_count + (N_IN + 1)'(mismatch);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of a combinational block gets a default first,
    // so no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = APPLY;
            APPLY:   if (timer_expired) next_state = CHECK;
            CHECK:   next_state = last_vec ? DONE : APPLY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dut_in      = '0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        timer_en    = (state == APPLY);
        timer_clear = (state == IDLE) || (state == CHECK);
        if (state == APPLY || state == CHECK) begin
            dut_in = vec;
        end
    end

    // Pass is resolved on the final CHECK edge so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vec       <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (last_vec) begin
                        pass <= (err_next == '0);
                    end else begin
                        vec <= vec + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OR_TESTER_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (state == IDLE && start) begin
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (state == CHECK && mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_or_gate_tester.sv
// Scoreboard bench for or_gate_tester against good and faulty behavioural OR DUTs.
// Define OR_TESTER_FIRST_FAIL_EN to also exercise the first-failure capture.
module tb_or_gate_tester;
    import or_tester_pkg::*;

    localparam int N    = DEF_N_IN;
    localparam int S    = DEF_SETTLE_CYCLES;
    localparam int NV   = 1 << N;
    localparam int RUN  = NV * (S + 1);

    localparam int MODE_OR    = 0;
    localparam int MODE_STUCK = 1;
    localparam int MODE_AND   = 2;

    typedef struct {
        logic [N-1:0] vin;
        bit           is_done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dut_in;
    logic         dut_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
`ifdef OR_TESTER_FIRST_FAIL_EN
    logic [N-1:0] first_fail_vec;
    logic         first_fail_valid;
`endif

    int   dut_mode;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic model_out(input int m, input logic [N-1:0] v);
        case (m)
            MODE_STUCK: return 1'b0;
            MODE_AND:   return &v;
            default:    return |v;
        endcase
    endfunction

    assign dut_out = model_out(dut_mode, dut_in);

    or_gate_tester #(
        .N_IN         (N),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count)
`ifdef OR_TESTER_FIRST_FAIL_EN
        ,
        .first_fail_vec  (first_fail_vec),
        .first_fail_valid(first_fail_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One full run: scoreboard holds the expected vector for every cycle of the run.
    task automatic run_and_check(input int mode, input bit repulse);
        int           exp_err = 0;
        int           exp_ff  = -1;
        logic [N-1:0] v;
        exp_t         e;
        dut_mode = mode;
        for (int i = 0; i < NV; i++) begin
            v = N'(i);
            if (model_out(mode, v) != (|v)) begin
                exp_err++;
                if (exp_ff < 0) exp_ff = i;
            end
            for (int r = 0; r <= S; r++) sb.push_back('{vin: v, is_done: 1'b0});
        end
        sb.push_back('{vin: '0, is_done: 1'b1});

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears_err", 32'(err_count), 32'd0);
        check("start_clears_pass", 32'(pass), 32'd0);
`ifdef OR_TESTER_FIRST_FAIL_EN
        check("start_clears_ff_valid", 32'(first_fail_valid), 32'd0);
        check("start_clears_ff_vec", 32'(first_fail_vec), 32'd0);
`endif
        for (int c = 1; c <= RUN + 1; c++) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
                break;
            end
            e = sb.pop_front();
            if (e.is_done) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_in_done", 32'(busy), 32'd1);
            end else begin
                check("dut_in", 32'(dut_in), 32'(e.vin));
                check("busy_in_run", 32'(busy), 32'd1);
                check("no_early_done", 32'(done), 32'd0);
            end
            start = repulse && (c == 5 || c == 20 || c == RUN + 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("idle_after_run", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("err_count", 32'(err_count), 32'(exp_err));
        check("pass", 32'(pass), 32'(exp_err == 0));
`ifdef OR_TESTER_FIRST_FAIL_EN
        check("ff_valid", 32'(first_fail_valid), 32'(exp_ff >= 0));
        check("ff_vec", 32'(first_fail_vec), (exp_ff >= 0) ? 32'(exp_ff) : 32'd0);
`endif
        repeat (2) @(negedge clk);
        check("err_count_held", 32'(err_count), 32'(exp_err));
        check("pass_held", 32'(pass), 32'(exp_err == 0));
        check("stay_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dut_mode = MODE_OR;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_dut_in", 32'(dut_in), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_and_check(MODE_OR, 1'b0);
        run_and_check(MODE_STUCK, 1'b0);
        run_and_check(MODE_AND, 1'b1);
        run_and_check(MODE_OR, 1'b0);

        // Reset in the middle of a run while vector 011 is applied.
        dut_mode = MODE_STUCK;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * (S + 1)) @(negedge clk);
        check("pre_rst_dut_in", 32'(dut_in), 32'd3);
        check("pre_rst_err", 32'(err_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dut_in", 32'(dut_in), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 32'd0);
            check("post_rst_idle", 32'(busy), 32'd0);
        end
        run_and_check(MODE_AND, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
